// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and limits for the unified memory arbiter.
//   arb_state_t  - arbiter FSM state (idle / waiting on a read)
//   arb_owner_t  - which core port owns the current memory access
//   READ_LATENCY_MAX, LAT_CNT_W - bound on memory read latency and the
//                  width of the latency down-counter that covers it
package mem_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
    typedef enum logic {OWNER_INST, OWNER_DATA} arb_owner_t;

    localparam int READ_LATENCY_MAX = 4;
    localparam int LAT_CNT_W        = $clog2(READ_LATENCY_MAX);

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: combinational winner selection between fetch and data.
//   inst_req        in  fetch port requesting
//   data_req        in  data port requesting
//   streak_at_limit in  data has used up its consecutive-grant budget
//   owner           out winning port
//   valid           out some port is requesting (owner is meaningful)
// Data has priority; fetch wins when data is absent or when data's streak
// budget is exhausted while fetch is waiting.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic       inst_req,
    input  logic       data_req,
    input  logic       streak_at_limit,
    output arb_owner_t owner,
    output logic       valid
);

    always_comb begin
        valid = inst_req | data_req;
        owner = OWNER_DATA;
        if (inst_req && (!data_req || streak_at_limit))
            owner = OWNER_INST;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, non-pipelined memory between the
// core's instruction-fetch port and data port.
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/addr                 fetch request (held until inst_grant)
//   inst_grant/rvalid/rd_data     fetch accept, read-data pulse, fetched word
//   data_req/wr/addr/wr_data      data request (held until data_grant)
//   data_grant/rvalid/rd_data     data accept, read-data pulse, loaded word
//   mem_addr/wr_data/wr_ena       memory request side
//   mem_rd_data                   memory read data, READ_LATENCY after issue
//   busy                          high while waiting on a read
// Optional build macro MEM_ARBITER_PERF_COUNTERS_EN adds inst_wait_cycles and
// data_wait_cycles: wrapping counts of cycles a port requested but was not
// granted.
// Parameters: READ_LATENCY (1..4), MAX_DATA_STREAK (0 = strict data priority).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int READ_LATENCY    = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_grant,
    output logic        inst_rvalid,
    output logic [31:0] inst_rd_data,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    output logic        data_grant,
    output logic        data_rvalid,
    output logic [31:0] data_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data,
    output logic        busy
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
    ,
    output logic [31:0] inst_wait_cycles,
    output logic [31:0] data_wait_cycles
`endif
);

    // A zero-width counter is illegal, so strict-priority builds keep one
    // (never incremented) bit.
    localparam int STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = LAT_CNT_W'(READ_LATENCY - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    arb_owner_t           r_owner;
    logic [31:0]          r_addr;
    logic [LAT_CNT_W-1:0] r_lat_cnt;
    logic [STREAK_W-1:0]  r_streak;
    logic [31:0]          r_inst_rd_data;
    logic [31:0]          r_data_rd_data;

    arb_owner_t           w_pick_owner;
    logic                 w_pick_vld;
    logic                 w_streak_full;
    logic                 w_issue_rd;

    assign w_streak_full = (r_streak == STREAK_MAX);

    mem_arbiter_pick u_pick (
        .inst_req        (inst_req),
        .data_req        (data_req),
        .streak_at_limit ((MAX_DATA_STREAK > 0) && w_streak_full),
        .owner           (w_pick_owner),
        .valid           (w_pick_vld)
    );

    // Grants and memory strobes are combinational from the winner; reset
    // forces everything quiet for the whole rst cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_issue_rd  = 1'b0;
        inst_grant  = 1'b0;
        data_grant  = 1'b0;
        inst_rvalid = 1'b0;
        data_rvalid = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_vld) begin
                        if (w_pick_owner == OWNER_DATA) begin
                            data_grant  = 1'b1;
                            mem_addr    = data_addr;
                            mem_wr_data = data_wr_data;
                            mem_wr_ena  = data_wr;
                            w_issue_rd  = !data_wr;
                        end else begin
                            inst_grant  = 1'b1;
                            mem_addr    = inst_addr;
                            w_issue_rd  = 1'b1;
                        end
                        // Writes complete in the grant cycle; only reads wait.
                        if (w_issue_rd)
                            w_state_nxt = ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    busy     = 1'b1;
                    mem_addr = r_addr;
                    if (r_lat_cnt == '0) begin
                        inst_rvalid = (r_owner == OWNER_INST);
                        data_rvalid = (r_owner == OWNER_DATA);
                        w_state_nxt = ARB_IDLE;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    // Read data bypasses straight from memory in the rvalid cycle; the
    // registered copy holds it afterwards until the next rvalid.
    assign inst_rd_data = inst_rvalid ? mem_rd_data : r_inst_rd_data;
    assign data_rd_data = data_rvalid ? mem_rd_data : r_data_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB_IDLE;
            r_owner        <= OWNER_INST;
            r_addr         <= '0;
            r_lat_cnt      <= '0;
            r_streak       <= '0;
            r_inst_rd_data <= '0;
            r_data_rd_data <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_issue_rd) begin
                r_owner   <= data_grant ? OWNER_DATA : OWNER_INST;
                r_addr    <= mem_addr;
                r_lat_cnt <= LAT_LOAD;
            end else if (r_state == ARB_WAIT && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end

            if (inst_rvalid) r_inst_rd_data <= mem_rd_data;
            if (data_rvalid) r_data_rd_data <= mem_rd_data;

            // Streak only measures data grants taken while fetch is waiting.
            if (!inst_req || inst_grant)
                r_streak <= '0;
            else if (data_grant && !w_streak_full)
                r_streak <= r_streak + 1'b1;
        end
    end

`ifdef MEM_ARBITER_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_wait_cycles <= '0;
            data_wait_cycles <= '0;
        end else begin
            if (inst_req && !inst_grant) inst_wait_cycles <= inst_wait_cycles + 32'd1;
            if (data_req && !data_grant) data_wait_cycles <= data_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a read-data scoreboard.
// Instance A: READ_LATENCY=1, MAX_DATA_STREAK=4.
// Instance B: READ_LATENCY=3, MAX_DATA_STREAK=2.
// Each instance drives a small behavioural memory; read expectations are
// queued when a read is requested and checked when rvalid appears.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // instance A signals
    logic        a_rst, a_inst_req, a_inst_grant, a_inst_rvalid;
    logic [31:0] a_inst_addr, a_inst_rd_data;
    logic        a_data_req, a_data_wr, a_data_grant, a_data_rvalid;
    logic [31:0] a_data_addr, a_data_wr_data, a_data_rd_data;
    logic [31:0] a_mem_addr, a_mem_wr_data, a_mem_rd_data;
    logic        a_mem_wr_ena, a_busy;
    // instance B signals
    logic        b_rst, b_inst_req, b_inst_grant, b_inst_rvalid;
    logic [31:0] b_inst_addr, b_inst_rd_data;
    logic        b_data_req, b_data_wr, b_data_grant, b_data_rvalid;
    logic [31:0] b_data_addr, b_data_wr_data, b_data_rd_data;
    logic [31:0] b_mem_addr, b_mem_wr_data, b_mem_rd_data;
    logic        b_mem_wr_ena, b_busy;
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
    logic [31:0] a_inst_wait, a_data_wait, b_inst_wait, b_data_wait;
`endif

    mem_arbiter #(.READ_LATENCY(1), .MAX_DATA_STREAK(4)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_grant(a_inst_grant),
        .inst_rvalid(a_inst_rvalid), .inst_rd_data(a_inst_rd_data),
        .data_req(a_data_req), .data_wr(a_data_wr), .data_addr(a_data_addr),
        .data_wr_data(a_data_wr_data), .data_grant(a_data_grant),
        .data_rvalid(a_data_rvalid), .data_rd_data(a_data_rd_data),
        .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wr_data), .mem_wr_ena(a_mem_wr_ena),
        .mem_rd_data(a_mem_rd_data), .busy(a_busy)
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
        , .inst_wait_cycles(a_inst_wait), .data_wait_cycles(a_data_wait)
`endif
    );

    mem_arbiter #(.READ_LATENCY(3), .MAX_DATA_STREAK(2)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_grant(b_inst_grant),
        .inst_rvalid(b_inst_rvalid), .inst_rd_data(b_inst_rd_data),
        .data_req(b_data_req), .data_wr(b_data_wr), .data_addr(b_data_addr),
        .data_wr_data(b_data_wr_data), .data_grant(b_data_grant),
        .data_rvalid(b_data_rvalid), .data_rd_data(b_data_rd_data),
        .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wr_data), .mem_wr_ena(b_mem_wr_ena),
        .mem_rd_data(b_mem_rd_data), .busy(b_busy)
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
        , .inst_wait_cycles(b_inst_wait), .data_wait_cycles(b_data_wait)
`endif
    );

    // Contents of a never-written memory word.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'd7);
    endfunction

    // Behavioural memories: registered read of the presented address, so
    // data is valid the cycle after issue and stays valid while the arbiter
    // holds the address.
    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];
    logic [4095:0] wr_a, wr_b;

    always_ff @(posedge clk) begin
        if (a_rst) wr_a <= '0;
        else if (a_mem_wr_ena) begin
            wr_a[a_mem_addr[13:2]]  <= 1'b1;
            mem_a[a_mem_addr[13:2]] <= a_mem_wr_data;
        end
        a_mem_rd_data <= wr_a[a_mem_addr[13:2]] ? mem_a[a_mem_addr[13:2]] : exp_word(a_mem_addr);
    end

    always_ff @(posedge clk) begin
        if (b_rst) wr_b <= '0;
        else if (b_mem_wr_ena) begin
            wr_b[b_mem_addr[13:2]]  <= 1'b1;
            mem_b[b_mem_addr[13:2]] <= b_mem_wr_data;
        end
        b_mem_rd_data <= wr_b[b_mem_addr[13:2]] ? mem_b[b_mem_addr[13:2]] : exp_word(b_mem_addr);
    end

    logic [31:0] exp_a_inst[$], exp_a_data[$], exp_b_inst[$], exp_b_data[$];
    logic [1:0]  glog[$];        // B grant order: 2'b01 data, 2'b10 inst
    logic        log_en = 1'b0;
    logic [1:0]  ptn [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Negedge sample point: scoreboard pops on every rvalid.
    task automatic sample();
        @(negedge clk);
        if (a_inst_rvalid) begin
            chk("a_inst_sb_pending", 32'(exp_a_inst.size() != 0), 32'd1);
            if (exp_a_inst.size() != 0) chk("a_inst_rd_data", a_inst_rd_data, exp_a_inst.pop_front());
        end
        if (a_data_rvalid) begin
            chk("a_data_sb_pending", 32'(exp_a_data.size() != 0), 32'd1);
            if (exp_a_data.size() != 0) chk("a_data_rd_data", a_data_rd_data, exp_a_data.pop_front());
        end
        if (b_inst_rvalid) begin
            chk("b_inst_sb_pending", 32'(exp_b_inst.size() != 0), 32'd1);
            if (exp_b_inst.size() != 0) chk("b_inst_rd_data", b_inst_rd_data, exp_b_inst.pop_front());
        end
        if (b_data_rvalid) begin
            chk("b_data_sb_pending", 32'(exp_b_data.size() != 0), 32'd1);
            if (exp_b_data.size() != 0) chk("b_data_rd_data", b_data_rd_data, exp_b_data.pop_front());
        end
        if (log_en && (b_inst_grant || b_data_grant))
            glog.push_back({b_inst_grant, b_data_grant});
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_inst_req = 0; a_inst_addr = 0; a_data_req = 0; a_data_wr = 0;
        a_data_addr = 0; a_data_wr_data = 0;
        b_rst = 1'b1; b_inst_req = 0; b_inst_addr = 0; b_data_req = 0; b_data_wr = 0;
        b_data_addr = 0; b_data_wr_data = 0;
        adv();

        // Reset cycle with requests pending: nothing may be granted.
        a_inst_req = 1; a_inst_addr = 32'h100;
        b_data_req = 1; b_data_addr = 32'h40;
        sample();
        chk("rst_a_inst_grant", a_inst_grant, 0);
        chk("rst_a_mem_addr", a_mem_addr, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_inst_rd_data", a_inst_rd_data, 0);
        chk("rst_b_data_grant", b_data_grant, 0);
        chk("rst_b_mem_wr_data", b_mem_wr_data, 0);
        adv();

        // Single fetch, latency 1.
        a_rst = 0; b_rst = 0; b_data_req = 0;
        exp_a_inst.push_back(32'h0000_0013);
        sample();
        chk("a_fetch_grant", a_inst_grant, 1);
        chk("a_fetch_mem_addr", a_mem_addr, 32'h100);
        chk("a_fetch_wr_ena", a_mem_wr_ena, 0);
        chk("a_fetch_busy0", a_busy, 0);
        adv();
        a_inst_req = 0;
        sample();
        chk("a_fetch_busy1", a_busy, 1);
        chk("a_fetch_rvalid", a_inst_rvalid, 1);
        chk("a_fetch_no_grant_wait", a_inst_grant, 0);
        adv();
        sample();
        chk("a_fetch_busy_after", a_busy, 0);
        chk("a_fetch_rvalid_after", a_inst_rvalid, 0);
        chk("a_fetch_rd_held", a_inst_rd_data, 32'h13);
        adv();

        // Simultaneous fetch and data read: data first.
        a_inst_req = 1; a_inst_addr = 32'h200;
        a_data_req = 1; a_data_wr = 0; a_data_addr = 32'h1000;
        exp_a_data.push_back(exp_word(32'h1000));
        exp_a_inst.push_back(exp_word(32'h200));
        sample();
        chk("a_sim_data_grant", a_data_grant, 1);
        chk("a_sim_inst_loses", a_inst_grant, 0);
        chk("a_sim_mem_addr", a_mem_addr, 32'h1000);
        adv();
        a_data_req = 0;
        sample();
        chk("a_sim_wait_busy", a_busy, 1);
        chk("a_sim_wait_no_grant", a_inst_grant, 0);
        chk("a_sim_wait_addr", a_mem_addr, 32'h1000);
        chk("a_sim_data_rvalid", a_data_rvalid, 1);
        adv();
        sample();
        chk("a_sim_inst_grant", a_inst_grant, 1);
        chk("a_sim_inst_addr", a_mem_addr, 32'h200);
        adv();
        a_inst_req = 0;
        sample();
        chk("a_sim_inst_rvalid", a_inst_rvalid, 1);
        adv();

        // Back-to-back writes: one-cycle strobes, no rvalid.
        a_data_req = 1; a_data_wr = 1; a_data_addr = 32'h2000; a_data_wr_data = 32'hDEAD_BEEF;
        sample();
        chk("a_wr_grant", a_data_grant, 1);
        chk("a_wr_ena", a_mem_wr_ena, 1);
        chk("a_wr_data", a_mem_wr_data, 32'hDEAD_BEEF);
        chk("a_wr_addr", a_mem_addr, 32'h2000);
        chk("a_wr_busy", a_busy, 0);
        adv();
        a_data_addr = 32'h2004; a_data_wr_data = 32'h1234_5678;
        sample();
        chk("a_wr2_grant", a_data_grant, 1);
        chk("a_wr2_ena", a_mem_wr_ena, 1);
        chk("a_wr2_data", a_mem_wr_data, 32'h1234_5678);
        chk("a_wr2_no_rvalid", a_data_rvalid, 0);
        adv();
        a_data_req = 0; a_data_wr = 0;
        sample();
        chk("a_wr_ena_off", a_mem_wr_ena, 0);
        chk("a_wr_no_rvalid", a_data_rvalid, 0);
        chk("a_idle_mem_addr", a_mem_addr, 0);
        adv();

        // Read back the stored word.
        a_data_req = 1; a_data_addr = 32'h2000;
        exp_a_data.push_back(32'hDEAD_BEEF);
        sample();
        chk("a_rb_grant", a_data_grant, 1);
        adv();
        a_data_req = 0;
        sample();
        chk("a_rb_rvalid", a_data_rvalid, 1);
        adv();

        // Reset, then fetch starved by data until the 4-grant streak limit.
        a_rst = 1;
        sample();
        adv();
        a_rst = 0;
        a_inst_req = 1; a_inst_addr = 32'h104;
        a_data_req = 1; a_data_wr = 0; a_data_addr = 32'h500;
        exp_a_data.push_back(exp_word(32'h500));
        exp_a_inst.push_back(exp_word(32'h104));
        sample();
        chk("a_str_rd_grant", a_data_grant, 1);
        chk("a_str_rd_inst0", a_inst_grant, 0);
        adv();
        a_data_req = 0;
        sample();
        chk("a_str_rd_rvalid", a_data_rvalid, 1);
        adv();
        a_data_req = 1; a_data_wr = 1; a_data_addr = 32'h600; a_data_wr_data = 32'h1;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("a_str_wr_grant", a_data_grant, 1);
            chk("a_str_wr_inst0", a_inst_grant, 0);
            adv();
        end
        sample();
        chk("a_str_limit_inst", a_inst_grant, 1);
        chk("a_str_limit_data", a_data_grant, 0);
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
        chk("a_perf_inst_wait", a_inst_wait, 32'd5);
        chk("a_perf_data_wait", a_data_wait, 32'd0);
`endif
        adv();
        a_inst_req = 0; a_data_req = 0; a_data_wr = 0;
        sample();
        chk("a_str_inst_rvalid", a_inst_rvalid, 1);
        adv();

        // B: continuous writes vs continuous fetch, streak limit 2.
        b_inst_req = 1; b_inst_addr = 32'h300;
        b_data_req = 1; b_data_wr = 1; b_data_addr = 32'h3000; b_data_wr_data = 32'hA;
        exp_b_inst.push_back(exp_word(32'h300));
        exp_b_inst.push_back(exp_word(32'h300));
        log_en = 1;
        for (int k = 0; k < 12; k++) begin
            sample();
            adv();
        end
        log_en = 0;
        b_inst_req = 0; b_data_req = 0; b_data_wr = 0;
        chk("b_glog_len", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < glog.size()) chk($sformatf("b_glog_%0d", i), 32'(glog[i]), 32'(ptn[i]));

        // B: read in flight killed by reset.
        b_data_req = 1; b_data_wr = 0; b_data_addr = 32'h40;
        sample();
        chk("b_kill_grant", b_data_grant, 1);
        chk("b_kill_addr", b_mem_addr, 32'h40);
        adv();
        b_data_req = 0; b_rst = 1;
        sample();
        chk("b_rst_busy", b_busy, 0);
        chk("b_rst_mem_addr", b_mem_addr, 0);
        chk("b_rst_rvalid", b_data_rvalid, 0);
        chk("b_rst_wr_ena", b_mem_wr_ena, 0);
        adv();
        b_rst = 0;
        sample();
        chk("b_post_busy", b_busy, 0);
        chk("b_post_mem_addr", b_mem_addr, 0);
        chk("b_post_rd_data", b_data_rd_data, 0);
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
        chk("b_post_inst_wait", b_inst_wait, 0);
        chk("b_post_data_wait", b_data_wait, 0);
`endif
        adv();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("b_no_rvalid_after_rst", b_data_rvalid, 0);
            adv();
        end

        // B: fresh read, latency 3.
        b_data_req = 1; b_data_addr = 32'h44;
        exp_b_data.push_back(exp_word(32'h44));
        sample();
        chk("b_fresh_grant", b_data_grant, 1);
        adv();
        b_data_req = 0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk($sformatf("b_lat3_rvalid_%0d", k), b_data_rvalid, 32'(k == 2));
            chk($sformatf("b_lat3_busy_%0d", k), b_busy, 1);
            adv();
        end
        sample();
        chk("b_lat3_idle", b_busy, 0);
        adv();

        chk("sb_a_inst_empty", 32'(exp_a_inst.size()), 0);
        chk("sb_a_data_empty", 32'(exp_a_data.size()), 0);
        chk("sb_b_inst_empty", 32'(exp_b_inst.size()), 0);
        chk("sb_b_data_empty", 32'(exp_b_data.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
